// File: rtl/dec3_to_8.sv
// dec3_to_8: registered 3-to-8 one-hot decoder with an active-high enable.
// Optional macro DEC3_8_INPUT_REG_EN adds an input register stage, which raises
// the latency from 1 to 2 cycles. Parameter OUT_ACTIVE_LOW inverts the output
// polarity, so the selected line is 0 and every other line is 1.
module dec3_to_8 #(
  parameter int unsigned OUT_ACTIVE_LOW = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] a,
  input  logic       enn,
  output logic [7:0] d,
  output logic       dv
);

  localparam int unsigned SEL_W = 3;
  localparam int unsigned OUT_W = 8;
  localparam logic [OUT_W-1:0] INACTIVE = (OUT_ACTIVE_LOW != 0) ? {OUT_W{1'b1}} : {OUT_W{1'b0}};

  logic [SEL_W-1:0] dec_a;
  logic             dec_en;
  logic [OUT_W-1:0] d_d, d_q;
  logic             dv_d, dv_q;

`ifdef DEC3_8_INPUT_REG_EN
  logic [SEL_W-1:0] a_q;
  logic             enn_q;

  // Input capture stage; reset discards any value still in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= '0;
      enn_q <= 1'b0;
    end else begin
      a_q   <= a;
      enn_q <= enn;
    end
  end

  assign dec_a  = a_q;
  assign dec_en = enn_q;
`else
  assign dec_a  = a;
  assign dec_en = enn;
`endif

  // One-hot decode; a low enable forces every line to the inactive level
  always_comb begin
    d_d  = '0;
    dv_d = dec_en;
    for (int i = 0; i < int'(OUT_W); i++) begin
      d_d[i] = dec_en && (dec_a == SEL_W'(i));
    end
    if (OUT_ACTIVE_LOW != 0) begin
      d_d = ~d_d;
    end
  end

  // Output register keeps d and dv aligned and glitch-free
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_q  <= INACTIVE;
      dv_q <= 1'b0;
    end else begin
      d_q  <= d_d;
      dv_q <= dv_d;
    end
  end

  assign d  = d_q;
  assign dv = dv_q;

endmodule

// File: tb/tb_dec3_to_8.sv
// tb_dec3_to_8: directed checks of dec3_to_8 in both output polarities.
// Honours DEC3_8_INPUT_REG_EN so the expected latency matches the build.
module tb_dec3_to_8;

`ifdef DEC3_8_INPUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] a   = 3'd0;
  logic       enn = 1'b0;
  logic [7:0] d_hi, d_lo;
  logic       dv_hi, dv_lo;

  int n_cmp  = 0;
  int n_fail = 0;

  dec3_to_8 #(.OUT_ACTIVE_LOW(0)) u_hi (
    .clk(clk), .rst(rst), .a(a), .enn(enn), .d(d_hi), .dv(dv_hi)
  );

  dec3_to_8 #(.OUT_ACTIVE_LOW(1)) u_lo (
    .clk(clk), .rst(rst), .a(a), .enn(enn), .d(d_lo), .dv(dv_lo)
  );

  always #5 clk = ~clk;

  // Drive a new vector on the falling edge
  task automatic apply(input logic [2:0] av, input logic ev);
    @(negedge clk);
    a   = av;
    enn = ev;
  endtask

  task automatic wait_lat();
    repeat (LAT) @(negedge clk);
  endtask

  task automatic test_reset();
    a = 3'd7; enn = 1'b1;
    #1 rst = 1'b1;
    #2;
    n_cmp++; if (d_hi !== 8'h00) begin n_fail++; $display("FAIL reset_d_hi got %h want 00", d_hi); end
    n_cmp++; if (dv_hi !== 1'b0) begin n_fail++; $display("FAIL reset_dv_hi got %b want 0", dv_hi); end
    n_cmp++; if (d_lo !== 8'hFF) begin n_fail++; $display("FAIL reset_d_lo got %h want FF", d_lo); end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (d_hi !== 8'h00) begin n_fail++; $display("FAIL reset_hold_d_hi got %h want 00", d_hi); end
    n_cmp++; if (d_lo !== 8'hFF || dv_lo !== 1'b0) begin n_fail++; $display("FAIL reset_hold_lo got %h/%b want FF/0", d_lo, dv_lo); end
    @(negedge clk);
    rst = 1'b0;
    enn = 1'b0;
    repeat (LAT + 1) @(negedge clk);
  endtask

  task automatic test_sweep();
    logic [7:0] exp_d [8];
    exp_d = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    for (int i = 0; i < 8 + LAT; i++) begin
      @(negedge clk);
      if (i >= LAT) begin
        n_cmp++; if (d_hi !== exp_d[i-LAT]) begin n_fail++; $display("FAIL sweep_d_hi[%0d] got %h want %h", i-LAT, d_hi, exp_d[i-LAT]); end
        n_cmp++; if (dv_hi !== 1'b1) begin n_fail++; $display("FAIL sweep_dv[%0d] got %b want 1", i-LAT, dv_hi); end
        n_cmp++; if (d_lo !== ~exp_d[i-LAT]) begin n_fail++; $display("FAIL sweep_d_lo[%0d] got %h want %h", i-LAT, d_lo, ~exp_d[i-LAT]); end
        n_cmp++; if ($countones(d_hi) > 1 || $countones(~d_lo) > 1) begin n_fail++; $display("FAIL sweep_onehot[%0d] got %h/%h want <=1 active", i-LAT, d_hi, d_lo); end
      end
      if (i < 8) begin a = 3'(i); enn = 1'b1; end
      else begin a = 3'd0; enn = 1'b0; end
    end
  endtask

  task automatic test_disable();
    apply(3'd3, 1'b0);
    wait_lat();
    n_cmp++; if (d_hi !== 8'h00 || dv_hi !== 1'b0) begin n_fail++; $display("FAIL disable_hi got %h/%b want 00/0", d_hi, dv_hi); end
    n_cmp++; if (d_lo !== 8'hFF || dv_lo !== 1'b0) begin n_fail++; $display("FAIL disable_lo got %h/%b want FF/0", d_lo, dv_lo); end
    apply(3'd3, 1'b1);
    wait_lat();
    n_cmp++; if (d_hi !== 8'h08 || dv_hi !== 1'b1) begin n_fail++; $display("FAIL reenable_hi got %h/%b want 08/1", d_hi, dv_hi); end
    n_cmp++; if (d_lo !== 8'hF7) begin n_fail++; $display("FAIL reenable_lo got %h want F7", d_lo); end
  endtask

  task automatic test_active_low();
    apply(3'd2, 1'b1);
    wait_lat();
    n_cmp++; if (d_lo !== 8'hFB || dv_lo !== 1'b1) begin n_fail++; $display("FAIL actlow_sel got %h/%b want FB/1", d_lo, dv_lo); end
    n_cmp++; if (d_hi !== 8'h04) begin n_fail++; $display("FAIL actlow_ref_hi got %h want 04", d_hi); end
    apply(3'd2, 1'b0);
    wait_lat();
    n_cmp++; if (d_lo !== 8'hFF || dv_lo !== 1'b0) begin n_fail++; $display("FAIL actlow_dis got %h/%b want FF/0", d_lo, dv_lo); end
  endtask

  task automatic test_latency();
    logic [7:0] exp_first;
    exp_first = (LAT == 1) ? 8'h20 : 8'h00;
    apply(3'd0, 1'b0);
    repeat (LAT + 1) @(negedge clk);
    a = 3'd5; enn = 1'b1;
    @(negedge clk);
    n_cmp++; if (d_hi !== exp_first) begin n_fail++; $display("FAIL latency_edge1 got %h want %h", d_hi, exp_first); end
    a = 3'd0; enn = 1'b0;
    if (LAT == 2) @(negedge clk);
    n_cmp++; if (d_hi !== 8'h20 || dv_hi !== 1'b1) begin n_fail++; $display("FAIL latency_out got %h/%b want 20/1", d_hi, dv_hi); end
  endtask

  task automatic test_async_reset();
    apply(3'd5, 1'b1);
    wait_lat();
    n_cmp++; if (d_hi !== 8'h20) begin n_fail++; $display("FAIL pre_reset got %h want 20", d_hi); end
    a = 3'd6; enn = 1'b1;
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (d_hi !== 8'h00 || dv_hi !== 1'b0) begin n_fail++; $display("FAIL async_reset_hi got %h/%b want 00/0", d_hi, dv_hi); end
    n_cmp++; if (d_lo !== 8'hFF || dv_lo !== 1'b0) begin n_fail++; $display("FAIL async_reset_lo got %h/%b want FF/0", d_lo, dv_lo); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_lat();
    n_cmp++; if (d_hi !== 8'h40 || dv_hi !== 1'b1) begin n_fail++; $display("FAIL post_reset got %h/%b want 40/1", d_hi, dv_hi); end
  endtask

  task automatic test_back_to_back();
    logic [2:0] va [6];
    logic       ve [6];
    logic [7:0] xd [6];
    va = '{3'd7, 3'd0, 3'd4, 3'd4, 3'd1, 3'd6};
    ve = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    xd = '{8'h80, 8'h01, 8'h00, 8'h10, 8'h02, 8'h00};
    for (int i = 0; i < 6 + LAT; i++) begin
      @(negedge clk);
      if (i >= LAT) begin
        n_cmp++; if (d_hi !== xd[i-LAT]) begin n_fail++; $display("FAIL b2b_d[%0d] got %h want %h", i-LAT, d_hi, xd[i-LAT]); end
        n_cmp++; if (dv_hi !== ve[i-LAT] || dv_lo !== ve[i-LAT]) begin n_fail++; $display("FAIL b2b_dv[%0d] got %b/%b want %b", i-LAT, dv_hi, dv_lo, ve[i-LAT]); end
        n_cmp++; if (d_lo !== ~xd[i-LAT]) begin n_fail++; $display("FAIL b2b_d_lo[%0d] got %h want %h", i-LAT, d_lo, ~xd[i-LAT]); end
      end
      if (i < 6) begin a = va[i]; enn = ve[i]; end
      else begin a = 3'd0; enn = 1'b0; end
    end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_disable();
    test_active_low();
    test_latency();
    test_async_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
